// File: rtl/i2s_master_interface.sv
// I2S bus master: divides clk into BCLK/LR, serialises 24-bit L/R into 32-bit slots, deserialises codec data.
// Latency: sample accepted before frame start N is sent from pos 1 of frame N; captured rx appears at start of frame N+1.
// Backpressure: one-deep holding register; tx_ready low while full, emptied only at frame start; empty at frame start gives underrun.
module i2s_master_interface #(
    parameter int CLK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] tx_l,
    input  logic [23:0] tx_r,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [23:0] rx_l,
    output logic [23:0] rx_r,
    output logic        new_sample,
    output logic        underrun,
    output logic        i2s_bclk,
    output logic        i2s_lr,
    output logic        i2s_d_out,
    input  logic        i2s_d_in
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             bclk_reg;
    logic [5:0]       pos;
    logic [5:0]       pos_nxt;
    logic             lr_reg;
    logic             dout_reg;
    logic             dout_nxt;
    logic             new_sample_reg;
    logic             underrun_reg;
    logic             hold_full;
    logic [23:0]      hold_l;
    logic [23:0]      hold_r;
    logic [23:0]      word_l;
    logic [23:0]      word_r;
    logic [23:0]      cap_l;
    logic [23:0]      cap_r;
    logic [23:0]      rx_l_reg;
    logic [23:0]      rx_r_reg;
    logic             tick;
    logic             rise_ev;
    logic             fall_ev;
    logic             frame_start;
    logic             accept;

    assign tick        = (div == DIV_W'(CLK_DIV - 1));
    assign rise_ev     = tick && !bclk_reg;
    assign fall_ev     = tick && bclk_reg;
    assign pos_nxt     = pos + 6'd1;
    assign frame_start = fall_ev && (pos_nxt == 6'd0);
    assign accept      = tx_valid && !hold_full;

    assign tx_ready   = !hold_full;
    assign rx_l       = rx_l_reg;
    assign rx_r       = rx_r_reg;
    assign new_sample = new_sample_reg;
    assign underrun   = underrun_reg;
    assign i2s_bclk   = bclk_reg;
    assign i2s_lr     = lr_reg;
    assign i2s_d_out  = dout_reg;

    // Serial bit for the position being entered: MSB first, one BCLK after the LR edge, 8 pad bits per slot.
    always_comb begin
        dout_nxt = 1'b0;
        if (pos_nxt >= 6'd1 && pos_nxt <= 6'd24) begin
            dout_nxt = word_l[5'(6'd24 - pos_nxt)];
        end else if (pos_nxt >= 6'd33 && pos_nxt <= 6'd56) begin
            dout_nxt = word_r[5'(6'd56 - pos_nxt)];
        end
    end

    // BCLK divider: wrap at CLK_DIV-1 and toggle the bit clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            bclk_reg <= 1'b0;
        end else if (tick) begin
            div      <= '0;
            bclk_reg <= ~bclk_reg;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Frame position and all line/status outputs update on the falling BCLK event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos            <= 6'd63;
            lr_reg         <= 1'b0;
            dout_reg       <= 1'b0;
            new_sample_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else if (fall_ev) begin
            pos            <= pos_nxt;
            lr_reg         <= ~pos_nxt[5];
            dout_reg       <= dout_nxt;
            new_sample_reg <= frame_start;
            underrun_reg   <= frame_start && !hold_full;
        end else begin
            new_sample_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end
    end

    // Capture codec data on the rising BCLK event into the bit of the current slot position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_l <= '0;
            cap_r <= '0;
        end else if (rise_ev) begin
            if (pos >= 6'd1 && pos <= 6'd24) begin
                cap_l[5'(6'd24 - pos)] <= i2s_d_in;
            end else if (pos >= 6'd33 && pos <= 6'd56) begin
                cap_r[5'(6'd56 - pos)] <= i2s_d_in;
            end
        end
    end

    // Publish the previous frame's captures at frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_l_reg <= '0;
            rx_r_reg <= '0;
        end else if (frame_start) begin
            rx_l_reg <= cap_l;
            rx_r_reg <= cap_r;
        end
    end

    // Holding register feeds the tx word at frame start; an accept on an empty-register frame start waits a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            word_l    <= '0;
            word_r    <= '0;
        end else begin
            if (frame_start) begin
                word_l <= hold_full ? hold_l : 24'd0;
                word_r <= hold_full ? hold_r : 24'd0;
            end
            if (accept) begin
                hold_l    <= tx_l;
                hold_r    <= tx_r;
                hold_full <= 1'b1;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_master_interface.sv
// Scoreboard bench for i2s_master_interface with CLK_DIV=2 and i2s_d_in looped back from i2s_d_out.
// Stimulus pushes per-frame expected tx words; a monitor checks timing, serial data, LR, rx and underrun at each frame start.
// All waits are bounded; a watchdog ends the run if anything stalls.
module tb_i2s_master_interface;
    localparam int CLK_DIV = 2;
    localparam int FIRST   = 2 * CLK_DIV;
    localparam int FRAME   = 128 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] tx_l;
    logic [23:0] tx_r;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] rx_l;
    logic [23:0] rx_r;
    logic        new_sample;
    logic        underrun;
    logic        i2s_bclk;
    logic        i2s_lr;
    logic        i2s_d_out;
    logic        i2s_d_in;

    assign i2s_d_in = i2s_d_out;

    i2s_master_interface #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_l      (tx_l),
        .tx_r      (tx_r),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_l      (rx_l),
        .rx_r      (rx_r),
        .new_sample(new_sample),
        .underrun  (underrun),
        .i2s_bclk  (i2s_bclk),
        .i2s_lr    (i2s_lr),
        .i2s_d_out (i2s_d_out),
        .i2s_d_in  (i2s_d_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int          frame;
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int target_frame(input int c);
        if (c < FIRST) return 0;
        return (c - FIRST) / FRAME + 1;
    endfunction

    // Monitor state
    int          k;
    int          nrise;
    logic [63:0] bits;
    logic [63:0] lrb;
    logic        bprev;
    logic [23:0] prev_l;
    logic [23:0] prev_r;
    logic [23:0] el;
    logic [23:0] er;
    logic        eu;

    initial begin
        k = 0; nrise = 0; bits = '0; lrb = '0; bprev = 1'b0; prev_l = '0; prev_r = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                k = 0; nrise = 0; bits = '0; lrb = '0; bprev = 1'b0;
                prev_l = '0; prev_r = '0;
                q.delete();
            end else begin
                if (i2s_bclk && !bprev) begin
                    bits = {bits[62:0], i2s_d_out};
                    lrb  = {lrb[62:0], i2s_lr};
                    nrise++;
                end
                bprev = i2s_bclk;
                if (new_sample) begin
                    check("frame_time", 64'(cyc), 64'(FIRST + FRAME * k));
                    if (k > 0) begin
                        check("rise_count", 64'(nrise), 64'd64);
                        check("dout_frame", bits, {1'b0, prev_l, 8'h00, prev_r, 7'h00});
                        check("lr_frame", lrb, 64'hFFFF_FFFF_0000_0000);
                    end
                    check("rx_l", 64'(rx_l), 64'(prev_l));
                    check("rx_r", 64'(rx_r), 64'(prev_r));
                    if (q.size() > 0 && q[0].frame == k) begin
                        el = q[0].l; er = q[0].r; eu = 1'b0;
                        void'(q.pop_front());
                    end else begin
                        el = '0; er = '0; eu = 1'b1;
                    end
                    check("underrun", 64'(underrun), 64'(eu));
                    prev_l = el;
                    prev_r = er;
                    k++;
                    nrise = 0;
                end else begin
                    check("underrun_idle", 64'(underrun), 64'd0);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive one sample until handshake; called at a negedge, returns at the negedge after the accept.
    task automatic offer(input logic [23:0] l, input logic [23:0] r);
        logic rdy;
        bit   done;
        done     = 1'b0;
        tx_l     = l;
        tx_r     = r;
        tx_valid = 1'b1;
        for (int n = 0; n < 1000 && !done; n++) begin
            rdy = tx_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                q.push_back('{frame: target_frame(cyc), l: l, r: r});
                done = 1'b1;
            end
            @(negedge clk);
        end
        check("offer_accepted", 64'(done), 64'd1);
    endtask

    task automatic check_reset_values();
        check("rst_bclk", 64'(i2s_bclk), 64'd0);
        check("rst_lr", 64'(i2s_lr), 64'd0);
        check("rst_dout", 64'(i2s_d_out), 64'd0);
        check("rst_rx_l", 64'(rx_l), 64'd0);
        check("rst_rx_r", 64'(rx_r), 64'd0);
        check("rst_new_sample", 64'(new_sample), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
    endtask

    // Release reset at a negedge and check the first BCLK rise at clk 2 and fall at clk 4.
    task automatic start_seq();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("bclk_start", 64'(i2s_bclk), 64'((c == 2 || c == 3) ? 1 : 0));
        end
        check("lr_first_frame", 64'(i2s_lr), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tx_l = '0; tx_r = '0; tx_valid = 1'b0; rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values();
        start_seq();

        // Frame 0: single sample, lands in frame 1.
        offer(24'hA5C3F0, 24'h123456);
        tx_valid = 1'b0;
        check("tx_ready_full", 64'(tx_ready), 64'd0);
        wait_cyc(FIRST + FRAME);
        check("tx_ready_after_start", 64'(tx_ready), 64'd1);

        // Frame 1: loopback pattern for frame 2, then continuous valid for frames 3..6.
        offer(24'h800001, 24'h7FFFFF);
        for (int i = 0; i < 4; i++) offer(24'h100000 + 24'(i), 24'h200000 + 24'(i));
        tx_valid = 1'b0;

        // Accept exactly on the frame-7 start edge with an empty register: frame 7 underruns, frame 8 sends it.
        wait_cyc(FIRST + 7 * FRAME - 1);
        offer(24'h5A5A5A, 24'hC3C3C3);
        tx_valid = 1'b0;

        wait_cyc(FIRST + 8 * FRAME + 2);
        offer(24'h0F0F0F, 24'hF0F0F0);
        tx_valid = 1'b0;

        // Pending sample for frame 10, discarded by a reset in the right slot of frame 9.
        wait_cyc(FIRST + 9 * FRAME + 2);
        offer(24'h111111, 24'h222222);
        tx_valid = 1'b0;
        wait_cyc(FIRST + 9 * FRAME + 180);
        check("frames_before_reset", 64'(k), 64'd10);
        #2 rst = 1'b1;
        #1 check_reset_values();
        repeat (2) @(negedge clk);
        start_seq();
        wait_cyc(FIRST + 2 * FRAME + 2);
        check("frames_after_reset", 64'(k), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
